// File: rtl/riscv_pkg.sv
// Shared RV32I encoding constants, instruction-format and FSM-state types
// used by the instruction encoder and its bit packer.
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // addi x0,x0,0 -- written in place of any word that cannot be encoded
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_J,
    FMT_ILLEGAL
  } fmt_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCEPT,
    ST_WRITE,
    ST_DONE
  } state_t;

  // Map a major opcode onto the encoding format it uses
  function automatic fmt_t decode_fmt(input logic [6:0] op);
    fmt_t f;
    case (op)
      OP_R:             f = FMT_R;
      OP_IMM, OP_LOAD:  f = FMT_I;
      OP_STORE:         f = FMT_S;
      OP_BRANCH:        f = FMT_B;
      OP_JAL:           f = FMT_J;
      default:          f = FMT_ILLEGAL;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/instr_encoder_packer.sv
// instr_format_packer: purely combinational RV32I bit packer.
// Takes decoded fields plus the format and produces the 32-bit word.
// Optional macro ENCODER_RANGE_CHECK_EN flags immediates that do not fit
// their field (or are misaligned for B/J); without it the immediate is
// silently truncated to the field bits.
module instr_format_packer
  import riscv_pkg::*;
(
  input  fmt_t        fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic        funct7_5,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        range_err
);

  logic        imm_bad;
  logic [31:0] raw;

`ifdef ENCODER_RANGE_CHECK_EN
  logic signed [31:0] simm;
  assign simm = imm;

  // Flag immediates that fall outside the signed range of their field
  always_comb begin
    imm_bad = 1'b0;
    case (fmt)
      FMT_I, FMT_S: imm_bad = (simm < -32'sd2048) || (simm > 32'sd2047);
      FMT_B:        imm_bad = (simm < -32'sd4096) || (simm > 32'sd4094) || imm[0];
      FMT_J:        imm_bad = (simm < -32'sd1048576) || (simm > 32'sd1048574) || imm[0];
      default:      imm_bad = 1'b0;
    endcase
  end
`else
  logic unused_imm_hi;
  assign unused_imm_hi = ^imm[31:21];
  assign imm_bad       = 1'b0;
`endif

  // Scatter the fields into the format-specific bit layout
  always_comb begin
    raw = '0;
    case (fmt)
      FMT_R: raw = {1'b0, funct7_5, 5'b00000, rs2, rs1, funct3, rd, opcode};
      FMT_I: raw = {imm[11:0], rs1, funct3, rd, opcode};
      FMT_S: raw = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      FMT_B: raw = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      FMT_J: raw = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: raw = '0;
    endcase
  end

  assign range_err = imm_bad;
  assign word      = ((fmt == FMT_ILLEGAL) || imm_bad) ? NOP_WORD : raw;

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: loads a run of encoded RV32I instructions into memory.
// A start pulse captures base address and count; each accepted field set
// is packed and written one cycle later, addresses stepping by 4 and
// wrapping modulo 2^32. All outputs are registered.
// Optional macro ENCODER_RANGE_CHECK_EN enables immediate range checking
// in the packer (out-of-range immediates write a NOP and set err).
module instr_encoder
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic [7:0]  count,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic        funct7_5,
  input  logic [31:0] imm,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        err
);

  state_t      state;
  logic [7:0]  remaining;
  fmt_t        fmt;
  logic [31:0] packed_word;
  logic        range_err;
  logic        word_err;

  assign fmt      = decode_fmt(opcode);
  assign word_err = (fmt == FMT_ILLEGAL) || range_err;

  instr_format_packer u_packer (
    .fmt       (fmt),
    .opcode    (opcode),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .funct3    (funct3),
    .funct7_5  (funct7_5),
    .imm       (imm),
    .word      (packed_word),
    .range_err (range_err)
  );

  // Run-control FSM; every output is set on the transition into the state
  // in which it must be visible, so they stay mutually exclusive by design.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      remaining <= '0;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            mem_addr  <= base_addr;
            remaining <= count;
            err       <= 1'b0;
            busy      <= 1'b1;
            if (count == 8'd0) begin
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              in_ready <= 1'b1;
              state    <= ST_ACCEPT;
            end
          end
        end
        ST_ACCEPT: begin
          if (in_valid && in_ready) begin
            mem_wdata <= packed_word;
            err       <= err | word_err;
            in_ready  <= 1'b0;
            mem_we    <= 1'b1;
            state     <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          mem_we    <= 1'b0;
          mem_addr  <= mem_addr + 32'd4;
          remaining <= remaining - 8'd1;
          if (remaining == 8'd1) begin
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            in_ready <= 1'b1;
            state    <= ST_ACCEPT;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset, start, in_valid, funct7_5;
  logic [31:0] base_addr, imm;
  logic [7:0]  count;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic        in_ready, mem_we, busy, done, err;
  logic [31:0] mem_addr, mem_wdata;

  int errors = 0;
  int checks = 0;
  int hs_to  = 0;
  int cyc    = 0;
  int wr_n   = 0;
  int done_n = 0;
  int excl   = 0;
  logic [31:0] wr_addr [0:255];
  logic [31:0] wr_data [0:255];
  int          wr_cyc  [0:255];

  instr_encoder dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .count(count),
    .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode), .rd(rd), .rs1(rs1),
    .rs2(rs2), .funct3(funct3), .funct7_5(funct7_5), .imm(imm), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Write log, done counter and exclusivity monitor
  always @(negedge clk) begin
    if (mem_we) begin
      if (wr_n < 256) begin
        wr_addr[wr_n] = mem_addr;
        wr_data[wr_n] = mem_wdata;
        wr_cyc[wr_n]  = cyc;
      end
      wr_n++;
    end
    if (done) done_n++;
    if ((int'(mem_we) + int'(in_ready) + int'(done)) > 1) excl++;
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic begin_run(input logic [31:0] b, input logic [7:0] c);
    tick;
    start = 1'b1; base_addr = b; count = c;
    tick;
    start = 1'b0;
  endtask

  task automatic send(input logic [6:0] op, input logic [4:0] d, input logic [4:0] s1,
                      input logic [4:0] s2, input logic [2:0] f3, input logic f7,
                      input logic [31:0] im);
    bit got;
    tick;
    opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7_5 = f7; imm = im;
    in_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (in_ready) begin
        @(posedge clk);
        got = 1'b1;
      end else tick;
    end
    if (!got) hs_to++;
    tick;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output bit got);
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      if (done) got = 1'b1;
      else tick;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; base_addr = '0; count = '0;
    opcode = '0; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0; funct7_5 = 1'b0; imm = '0;
    tick; tick; tick;
    checks++;
    if ({in_ready, mem_we, busy, done, err} !== 5'b00000) begin
      errors++; $display("FAIL reset_ctrl: got %b want 00000", {in_ready, mem_we, busy, done, err});
    end
    checks++;
    if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", mem_addr); end
    checks++;
    if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h want 0", mem_wdata); end
    reset = 1'b0;
    tick;
  endtask

  task automatic test_rtype;
    int n0, d0;
    bit got;
    n0 = wr_n; d0 = done_n;
    begin_run(32'h100, 8'd2);
    checks++;
    if ({busy, in_ready} !== 2'b11) begin errors++; $display("FAIL r_busy: got %b want 11", {busy, in_ready}); end
    send(7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0);
    send(7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 32'd0);
    wait_done(got);
    checks++;
    if (!got) begin errors++; $display("FAIL r_done: got no done want done pulse"); end
    checks++;
    if (wr_n - n0 !== 2) begin errors++; $display("FAIL r_count: got %0d want 2", wr_n - n0); end
    checks++;
    if (wr_addr[n0] !== 32'h100 || wr_data[n0] !== 32'h002081B3) begin
      errors++; $display("FAIL r_add: got %h@%h want 002081b3@00000100", wr_data[n0], wr_addr[n0]);
    end
    checks++;
    if (wr_addr[n0+1] !== 32'h104 || wr_data[n0+1] !== 32'h402081B3) begin
      errors++; $display("FAIL r_sub: got %h@%h want 402081b3@00000104", wr_data[n0+1], wr_addr[n0+1]);
    end
    checks++;
    if (wr_cyc[n0+1] - wr_cyc[n0] !== 2) begin
      errors++; $display("FAIL r_throughput: got %0d cycles want 2", wr_cyc[n0+1] - wr_cyc[n0]);
    end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL r_err: got %b want 0", err); end
    tick;
    checks++;
    if ({busy, done} !== 2'b00 || done_n - d0 !== 1) begin
      errors++; $display("FAIL r_idle: got busy,done=%b pulses=%0d want 00 1", {busy, done}, done_n - d0);
    end
  endtask

  task automatic test_load_store;
    int n0;
    bit got;
    n0 = wr_n;
    begin_run(32'h200, 8'd2);
    send(7'b0000011, 5'd5, 5'd2, 5'd9, 3'd2, 1'b1, 32'd8);
    send(7'b0100011, 5'd7, 5'd2, 5'd5, 3'd2, 1'b0, 32'd12);
    wait_done(got);
    tick;
    checks++;
    if (wr_data[n0] !== 32'h00812283) begin errors++; $display("FAIL lw: got %h want 00812283", wr_data[n0]); end
    checks++;
    if (wr_data[n0+1] !== 32'h00512623 || wr_addr[n0+1] !== 32'h204) begin
      errors++; $display("FAIL sw: got %h@%h want 00512623@00000204", wr_data[n0+1], wr_addr[n0+1]);
    end
  endtask

  task automatic test_branch_jump;
    int n0;
    bit got;
    logic [31:0] exp_b5;
    logic        exp_err;
`ifdef ENCODER_RANGE_CHECK_EN
    exp_b5 = 32'h00000013; exp_err = 1'b1;
`else
    exp_b5 = 32'h00208263; exp_err = 1'b0;
`endif
    n0 = wr_n;
    begin_run(32'h300, 8'd4);
    send(7'b1100011, 5'd31, 5'd1, 5'd2, 3'd0, 1'b0, 32'hFFFFFFF8);
    send(7'b1101111, 5'd1, 5'd7, 5'd7, 3'd5, 1'b1, 32'd16);
    send(7'b0010011, 5'd1, 5'd0, 5'd4, 3'd0, 1'b1, 32'hFFFFFFFF);
    send(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'd5);
    wait_done(got);
    checks++;
    if (wr_data[n0] !== 32'hFE208CE3) begin errors++; $display("FAIL beq_neg8: got %h want fe208ce3", wr_data[n0]); end
    checks++;
    if (wr_data[n0+1] !== 32'h010000EF) begin errors++; $display("FAIL jal16: got %h want 010000ef", wr_data[n0+1]); end
    checks++;
    if (wr_data[n0+2] !== 32'hFFF00093) begin errors++; $display("FAIL addi_m1: got %h want fff00093", wr_data[n0+2]); end
    checks++;
    if (wr_data[n0+3] !== exp_b5) begin errors++; $display("FAIL beq_5: got %h want %h", wr_data[n0+3], exp_b5); end
    checks++;
    if (err !== exp_err) begin errors++; $display("FAIL beq_5_err: got %b want %b", err, exp_err); end
    tick;
  endtask

  task automatic test_illegal;
    int n0;
    bit got;
    n0 = wr_n;
    begin_run(32'h400, 8'd1);
    send(7'b1111111, 5'd1, 5'd2, 5'd3, 3'd1, 1'b0, 32'd0);
    wait_done(got);
    checks++;
    if (wr_data[n0] !== 32'h00000013) begin errors++; $display("FAIL illegal_nop: got %h want 00000013", wr_data[n0]); end
    tick; tick; tick;
    checks++;
    if ({busy, err} !== 2'b01) begin errors++; $display("FAIL err_sticky: got busy,err=%b want 01", {busy, err}); end
    begin_run(32'h0, 8'd0);
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL err_clear: got %b want 0", err); end
    tick;
  endtask

  task automatic test_backpressure;
    int n0;
    bit got;
    n0 = wr_n;
    begin_run(32'h500, 8'd1);
    for (int i = 0; i < 5; i++) tick;
    checks++;
    if (wr_n !== n0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_hold: got writes=%0d ready=%b want 0 1", wr_n - n0, in_ready);
    end
    send(7'b0010011, 5'd2, 5'd2, 5'd0, 3'd0, 1'b0, 32'd1);
    wait_done(got);
    tick;
    checks++;
    if (wr_n - n0 !== 1 || wr_addr[n0] !== 32'h500 || wr_data[n0] !== 32'h00110113) begin
      errors++; $display("FAIL bp_write: got %0d x %h@%h want 1 x 00110113@00000500", wr_n - n0, wr_data[n0], wr_addr[n0]);
    end
  endtask

  task automatic test_wrap;
    int n0;
    bit got;
    n0 = wr_n;
    begin_run(32'hFFFFFFFC, 8'd2);
    send(7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0);
    send(7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0);
    wait_done(got);
    tick;
    checks++;
    if (wr_addr[n0] !== 32'hFFFFFFFC || wr_addr[n0+1] !== 32'h00000000) begin
      errors++; $display("FAIL wrap: got %h,%h want fffffffc,00000000", wr_addr[n0], wr_addr[n0+1]);
    end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL wrap_err: got %b want 0", err); end
  endtask

  task automatic test_count_zero;
    int n0;
    n0 = wr_n;
    begin_run(32'h600, 8'd0);
    checks++;
    if ({done, busy, mem_we, in_ready} !== 4'b1100) begin
      errors++; $display("FAIL cnt0_done: got done,busy,we,ready=%b want 1100", {done, busy, mem_we, in_ready});
    end
    tick;
    checks++;
    if ({done, busy} !== 2'b00 || wr_n !== n0) begin
      errors++; $display("FAIL cnt0_idle: got done,busy=%b writes=%0d want 00 0", {done, busy}, wr_n - n0);
    end
  endtask

  task automatic test_start_while_busy;
    int n0, d0;
    bit got;
    n0 = wr_n; d0 = done_n;
    begin_run(32'h700, 8'd1);
    tick;
    start = 1'b1; base_addr = 32'h900; count = 8'd5;
    tick;
    start = 1'b0;
    send(7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0);
    wait_done(got);
    tick; tick;
    checks++;
    if (wr_n - n0 !== 1 || wr_addr[n0] !== 32'h700 || done_n - d0 !== 1 || busy !== 1'b0) begin
      errors++; $display("FAIL busy_start: got writes=%0d addr=%h dones=%0d busy=%b want 1 00000700 1 0",
                         wr_n - n0, wr_addr[n0], done_n - d0, busy);
    end
  endtask

  task automatic test_reset_mid;
    int n0, d0;
    n0 = wr_n; d0 = done_n;
    begin_run(32'hA00, 8'd3);
    send(7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0);
    tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    checks++;
    if ({busy, in_ready, mem_we} !== 3'b000 || mem_addr !== 32'h0) begin
      errors++; $display("FAIL rst_mid_state: got busy,ready,we=%b addr=%h want 000 0", {busy, in_ready, mem_we}, mem_addr);
    end
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) tick;
    in_valid = 1'b0;
    checks++;
    if (wr_n - n0 !== 1 || done_n - d0 !== 0) begin
      errors++; $display("FAIL rst_mid_abort: got writes=%0d dones=%0d want 1 0", wr_n - n0, done_n - d0);
    end
  endtask

  initial begin
    test_reset;
    test_rtype;
    test_load_store;
    test_branch_jump;
    test_illegal;
    test_backpressure;
    test_wrap;
    test_count_zero;
    test_start_while_busy;
    test_reset_mid;
    checks++;
    if (hs_to !== 0) begin errors++; $display("FAIL handshake_timeout: got %0d want 0", hs_to); end
    checks++;
    if (excl !== 0) begin errors++; $display("FAIL exclusive_outputs: got %0d overlaps want 0", excl); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have `reset`, input, 1 bit: synchronous, active-high.
REQ-003 SHALL have `start`, input, 1 bit: begins a load run; sampled only in IDLE.
REQ-004 SHALL have `base_addr`, input, 32 bits: first instruction-memory byte address, captured on `start`.
REQ-005 SHALL have `count`, input, 8 bits: number of instructions to encode, captured on `start`.
REQ-006 SHALL have `in_valid` (input, 1 bit) and `in_ready` (output, 1 bit): the field handshake.
REQ-007 SHALL have these field inputs: `opcode` [6:0], `rd` [4:0], `rs1` [4:0], `rs2` [4:0], `funct3` [2:0], `funct7_5` [0], `imm` [31:0] (signed byte value).
REQ-008 SHALL have the memory write port outputs `mem_we` (1 bit), `mem_addr` (32 bits) and `mem_wdata` (32 bits).
REQ-009 SHALL have `busy` (1), `done` (1, one-cycle pulse) and `err` (1, sticky per run) outputs.

Function
REQ-010 SHALL use the FSM states IDLE, ACCEPT, WRITE and DONE.
REQ-011 IDLE SHALL behave as follows: on `start`, capture `base_addr` and `count`, then go to ACCEPT; if `count`==0, go directly to DONE.
REQ-012 ACCEPT SHALL behave as follows: `in_ready`=1; on `in_valid`&`in_ready`, register the encoded word and go to WRITE; while `in_valid`=0, stay.
REQ-013 WRITE SHALL behave as follows: `mem_we`=1 for exactly one cycle with the current address and word; then address+=4 and remaining-=1; if remaining==0, go to DONE, else go to ACCEPT.
REQ-014 DONE SHALL pulse `done` for one cycle, then go to IDLE; `err` SHALL hold until the next accepted `start`.
REQ-015 Latency SHALL be one cycle from handshake to `mem_we`, and throughput one instruction per 2 cycles.
REQ-016 Encoding SHALL be selected by opcode:
- 0110011: R-type.
- 0010011 and 0000011: I-type, imm[11:0].
- 0100011: S-type.
- 1100011: B-type, imm[12:1].
- 1101111: J-type, imm[20:1].
REQ-017 An unsupported opcode SHALL cause 0x00000013 (NOP) to be written and `err` to be set.
REQ-018 Field usage SHALL follow the format:
- `funct7_5` is used only for R-type, at bit 30; bits 31 and 29:25 are 0.
- I-type uses `funct7_5` as 0.
- Unused fields are ignored.
REQ-019 `mem_addr` SHALL wrap modulo 2^32 without error.
REQ-020 `start` SHALL be ignored while `busy`; `busy`=1 in every state except IDLE.
REQ-021 `mem_we`, `in_ready` and `done` SHALL never be asserted in the same cycle.

Reset
REQ-022 Reset SHALL force IDLE and clear `in_ready`, `mem_we`, `mem_addr`, `mem_wdata`, `busy`, `done`, `err` and all counters to 0.
REQ-023 Reset asserted mid-run SHALL abort the run with no further writes and no `done` pulse.

Configuration
REQ-024 With `ENCODER_RANGE_CHECK_EN` defined, the block SHALL treat each of the following as an error, write the NOP and set `err`:
- an I/S imm outside -2048..2047;
- a B imm outside -4096..4094 or with bit0 set;
- a J imm outside ±1 MiB or with bit0 set.
REQ-025 Without the macro, the block SHALL truncate imm silently to the field bits and never set `err` from the immediate.

Structure
REQ-026 The opcode constants, the format enum (R, I, S, B, J, ILLEGAL) and the FSM state typedef SHALL live in the shared package `riscv_pkg`.
REQ-027 Bit packing SHALL be implemented in the combinational sub-module `instr_format_packer` (fields+format in, word+range_err out), and the FSM SHALL be in `instr_encoder`.

Verification
REQ-028 Scenario, R-type: start, base 0x100, count 2; add x3,x1,x2, then sub x3,x1,x2 -> writes 0x002081B3 @0x100 and 0x402081B3 @0x104, then `done` pulses.
REQ-029 Scenario, load/store: lw x5,8(x2) -> 0x00812283; sw x5,12(x2) -> 0x00512623.
REQ-030 Scenario, branch: beq x1,x2,-8 -> 0xFE208CE3. With the macro, beq imm=5 -> 0x00000013 and `err`=1. Without the macro, beq imm=5 -> the imm=4 encoding, `err`=0.
REQ-031 Scenario, backpressure and wrap: hold `in_valid` low 5 cycles in ACCEPT -> no write occurs. Base 0xFFFFFFFC, count 2 -> writes go to 0xFFFFFFFC then 0x00000000.
REQ-032 Scenario, edge controls:
- count 0 -> `done` on the cycle after `start` with no `mem_we`;
- reset after the first of 3 writes -> IDLE, no further writes, no `done`;
- `start` while `busy` -> ignored.
